// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Single-port data-memory responder for the RI5CY data bus (req/gnt/rvalid).
// Answers loads and stores from a local word-organised memory with a
// configurable grant stall and a fixed one-cycle response latency. While the
// LBIST test_mode_i is high no new transaction is accepted, so memory state is
// frozen during scan shifting. Granted transactions are counted (saturating).
//
// Parameters:
//   ADDR_WIDTH : byte-address width of local memory (depth 2^(ADDR_WIDTH-2) words)
//   GNT_STALL  : fixed stall cycles before grant, 0..15
//   OOR_RDATA  : load data returned for out-of-range addresses
//
// Build option:
//   DATA_RESP_RANDOM_STALL_EN : when defined, the stall value comes from the
//   low two bits of a free-running 16-bit LFSR (0..3) and GNT_STALL is ignored.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_ni         in   asynchronous active-low reset
//   test_mode_i    in   LBIST test mode, blocks new accepts
//   data_req_i     in   request from core
//   data_addr_i    in   byte address [31:0]
//   data_we_i      in   1 = store, 0 = load
//   data_be_i      in   store byte enables [3:0]
//   data_wdata_i   in   store data [31:0]
//   data_gnt_o     out  grant (combinational in the grant cycle)
//   data_rvalid_o  out  response valid (registered)
//   data_rdata_o   out  load data (registered, 0 for stores)
//   busy_o         out  FSM not in IDLE
//   served_cnt_o   out  saturating count of granted transactions [15:0]
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          GNT_STALL  = 0,
  parameter logic [31:0] OOR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_mode_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        busy_o,
  output logic [15:0] served_cnt_o
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              stall_cnt_q, stall_cnt_d;
  logic [3:0]              stall_val;
  logic                    gnt_raw;
  logic                    gnt;
  logic                    accept;
  logic                    in_range;
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic [15:0]             served_cnt_q;
  logic [31:0]             mem [DEPTH];

  // Byte offset within the word plays no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];

  // ---------------------------------------------------------------------------
  // Stall value source
  // ---------------------------------------------------------------------------
`ifdef DATA_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, advancing every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall_val = {2'b00, lfsr_q[1:0]};
`else
  assign stall_val = 4'(GNT_STALL);
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign in_range = (data_addr_i >> ADDR_WIDTH) == 32'd0;
  assign word_idx = data_addr_i[ADDR_WIDTH-1:2];
  assign accept   = data_req_i & ~test_mode_i;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order across processes.
      state_q     <= IDLE;
      stall_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    gnt_raw     = 1'b0;

    unique case (state_q)
      IDLE, RESP: begin
        // RESP also accepts, giving one transaction per cycle at stall 0.
        if (accept) begin
          if (stall_val == 4'd0) begin
            gnt_raw = 1'b1;
            state_d = RESP;
          end else begin
            stall_cnt_d = stall_val - 4'd1;
            state_d     = STALL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!accept) begin
          // Request withdrawn or scan started: abandon without access.
          stall_cnt_d = 4'd0;
          state_d     = IDLE;
        end else if (stall_cnt_q != 4'd0) begin
          stall_cnt_d = stall_cnt_q - 4'd1;
        end else begin
          gnt_raw = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is held low while reset is asserted even though it is combinational.
  assign gnt = gnt_raw & rst_ni;

  // ---------------------------------------------------------------------------
  // Memory: the access executes at the grant edge
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset; clearing it would need a per-word
  // reset network, and software must write before it reads anyway.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response and transaction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      served_cnt_q <= 16'd0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        if (data_we_i) begin
          rdata_q <= 32'd0;
        end else if (in_range) begin
          rdata_q <= mem[word_idx];
        end else begin
          rdata_q <= OOR_RDATA;
        end
        if (served_cnt_q != 16'hFFFF) begin
          served_cnt_q <= served_cnt_q + 16'd1;
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign busy_o        = (state_q != IDLE);
  assign served_cnt_o  = served_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two responders share stimulus: dut0 with no grant stall and dut3 with a
// three-cycle stall. Inputs change 1 time unit after the rising edge; outputs
// are compared 2 units later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        test_mode;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        gnt0, rvalid0, busy0;
  logic [31:0] rdata0;
  logic [15:0] cnt0;
  logic        gnt3, rvalid3, busy3;
  logic [31:0] rdata3;
  logic [15:0] cnt3;

  int checks;
  int failures;

  data_mem_responder #(.ADDR_WIDTH(16), .GNT_STALL(0), .OOR_RDATA(32'hDEAD_BEEF)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
    .data_req_i(req), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_rdata_o(rdata0), .busy_o(busy0), .served_cnt_o(cnt0)
  );

  data_mem_responder #(.ADDR_WIDTH(16), .GNT_STALL(3), .OOR_RDATA(32'hDEAD_BEEF)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
    .data_req_i(req), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_rdata_o(rdata3), .busy_o(busy3), .served_cnt_o(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upper bound on run time; the stimulus itself has no open-ended waits.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic tm);
    req       = r;
    we        = w;
    addr      = a;
    be        = b;
    wdata     = d;
    test_mode = tm;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();

    // Row k: inputs for cycle k; gnt is the combinational answer in cycle k,
    // the other fields are registered state left by the edges before it.
    //            req   we    addr          be    wdata          gnt   rv    rdata          busy  cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 16'd1};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0040, 4'h5, 32'hAABB_CCDD, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 16'd3};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h12BB_56DD, 1'b1, 16'd4};
    vecs[6]  = '{1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 16'd5};
    vecs[7]  = '{1'b1, 1'b1, 32'h0001_0000, 4'hF, 32'h1111_1111, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 16'd6};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 16'd7};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 16'd8};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 16'd8};

    // Reset state, with a request present to show the grant is masked.
    tick();
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0);
    #2;
    check("rst_gnt_masked", 32'(gnt0), 32'd0);
    check("rst_rvalid", 32'(rvalid0), 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Stall-0 traffic: store/load, byte enables, out-of-range accesses.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 1'b0);
      #2;
      check($sformatf("row%0d_gnt", i), 32'(gnt0), 32'(vecs[i].exp_gnt));
      check($sformatf("row%0d_rvalid", i), 32'(rvalid0), 32'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid) begin
        check($sformatf("row%0d_rdata", i), rdata0, vecs[i].exp_rdata);
      end
      check($sformatf("row%0d_busy", i), 32'(busy0), 32'(vecs[i].exp_busy));
      check($sformatf("row%0d_cnt", i), 32'(cnt0), 32'(vecs[i].exp_cnt));
      tick();
    end

    // Test mode: a store held for 10 cycles is never granted.
    drive(1'b1, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("tm_gnt_c%0d", i), 32'(gnt0), 32'd0);
      check($sformatf("tm_busy_c%0d", i), 32'(busy0), 32'd0);
      tick();
    end
    check("tm_cnt_frozen", 32'(cnt0), 32'd8);
    // Test mode dropped: immediate grant; then test mode rises during RESP.
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0);
    #2;
    check("tm_release_gnt", 32'(gnt0), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b1);
    #2;
    check("tm_resp_gnt", 32'(gnt0), 32'd0);
    check("tm_resp_rvalid", 32'(rvalid0), 32'd1);
    check("tm_no_write_rdata", rdata0, 32'h12BB_56DD);
    check("tm_resp_cnt", 32'(cnt0), 32'd9);
    tick();
    idle();
    #2;
    check("tm_after_rvalid", 32'(rvalid0), 32'd0);
    check("tm_after_busy", 32'(busy0), 32'd0);

    // Fresh reset before the stalled-grant sequences.
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Stall 3: request held, grant in cycle 3, rvalid in cycle 4.
    drive(1'b1, 1'b1, 32'h80, 4'hF, 32'h5A5A_5A5A, 1'b0);
    #2;
    check("s3_c0_gnt", 32'(gnt3), 32'd0);
    tick();
    #2;
    check("s3_c1_gnt", 32'(gnt3), 32'd0);
    check("s3_c1_busy", 32'(busy3), 32'd1);
    tick();
    #2;
    check("s3_c2_gnt", 32'(gnt3), 32'd0);
    tick();
    #2;
    check("s3_c3_gnt", 32'(gnt3), 32'd1);
    check("s3_c3_rvalid", 32'(rvalid3), 32'd0);
    tick();
    idle();
    #2;
    check("s3_c4_rvalid", 32'(rvalid3), 32'd1);
    check("s3_c4_rdata", rdata3, 32'd0);
    check("s3_c4_cnt", 32'(cnt3), 32'd1);
    tick();
    #2;
    check("s3_c5_rvalid", 32'(rvalid3), 32'd0);
    check("s3_c5_busy", 32'(busy3), 32'd0);
    tick();

    // Stall 3: request dropped in cycle 1 aborts with no grant.
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'd0, 1'b0);
    tick();
    idle();
    #2;
    check("abort_c1_gnt", 32'(gnt3), 32'd0);
    tick();
    #2;
    check("abort_busy", 32'(busy3), 32'd0);
    check("abort_cnt", 32'(cnt3), 32'd1);
    tick();
    tick();
    #2;
    check("abort_rvalid", 32'(rvalid3), 32'd0);

    // Stall 3: load of the stored word.
    tick();
    drive(1'b1, 1'b0, 32'h80, 4'h0, 32'd0, 1'b0);
    tick();
    tick();
    tick();
    #2;
    check("s3_load_gnt", 32'(gnt3), 32'd1);
    tick();
    idle();
    #2;
    check("s3_load_rvalid", 32'(rvalid3), 32'd1);
    check("s3_load_rdata", rdata3, 32'h5A5A_5A5A);
    check("s3_load_cnt", 32'(cnt3), 32'd2);
    tick();

    // Stall 3: test mode rising during STALL aborts to IDLE.
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'd0, 1'b1);
    #2;
    check("tm_stall_gnt", 32'(gnt3), 32'd0);
    tick();
    #2;
    check("tm_stall_busy", 32'(busy3), 32'd0);
    idle();
    tick();
    tick();
    #2;
    check("tm_stall_cnt", 32'(cnt3), 32'd2);
    check("tm_stall_rvalid", 32'(rvalid3), 32'd0);
    tick();

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'd0, 1'b0);
    tick();
    #2;
    check("mid_rst_pre_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy3), 32'd0);
    check("mid_rst_gnt", 32'(gnt3), 32'd0);
    check("mid_rst_rvalid", 32'(rvalid3), 32'd0);
    check("mid_rst_rdata", rdata3, 32'd0);
    check("mid_rst_cnt3", 32'(cnt3), 32'd0);
    check("mid_rst_cnt0", 32'(cnt0), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Counter saturation: back-to-back stall-0 grants every cycle.
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    #2;
    check("sat_fffe", 32'(cnt0), 32'h0000_FFFE);
    tick();
    #2;
    check("sat_ffff", 32'(cnt0), 32'h0000_FFFF);
    tick();
    tick();
    #2;
    check("sat_hold", 32'(cnt0), 32'h0000_FFFF);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Single-port data-memory responder for the RI5CY data bus (req/gnt/rvalid protocol). It sits on the core's data port in place of the RAM data side and answers loads and stores with a configurable grant stall and a fixed one-cycle response latency. The block observes the LBIST `test_mode` so that no memory state changes while scan patterns are shifted through the core. It also counts serviced transactions for bench and self-test use.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte-address width of local memory. Depth is 2^(ADDR_WIDTH-2) 32-bit words.
- `GNT_STALL`, default 0: fixed number of stall cycles before grant, range 0..15.
- `OOR_RDATA`, default 32'hDEAD_BEEF: read data returned for out-of-range addresses.

Ports:
- `clk_i` in 1: clock. Rising edge.
- `rst_ni` in 1: reset. Asynchronous, active-low.
- `test_mode_i` in 1: LBIST test mode. No new accepts while high.
- `data_req_i` in 1: request from core.
- `data_addr_i` in 32: byte address.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_be_i` in 4: byte enables for stores.
- `data_wdata_i` in 32: store data.
- `data_gnt_o` out 1: grant. Combinational in the grant cycle.
- `data_rvalid_o` out 1: response valid. Registered.
- `data_rdata_o` out 32: load data. Registered.
- `busy_o` out 1: FSM not in IDLE.
- `served_cnt_o` out 16: count of granted transactions. Saturating.

## Operation
- FSM states: IDLE, STALL, RESP. `busy_o` = (state != IDLE).
- Accept condition in IDLE or RESP: `data_req_i & ~test_mode_i`.
  - If stall value = 0: `data_gnt_o` = 1 in the same cycle. The access executes at that edge. Next state is RESP.
  - If stall value > 0: load stall counter with (stall − 1). Next state is STALL. `data_gnt_o` = 0.
- STALL:
  - `data_gnt_o` = 0 while counter != 0. Counter decrements each cycle.
  - When counter = 0 and `data_req_i` = 1: `data_gnt_o` = 1, access executes, next state is RESP.
  - If `data_req_i` drops or `test_mode_i` rises: abort to IDLE. No access, no grant.
- RESP:
  - `data_rvalid_o` = 1 for exactly one cycle.
  - The same cycle also evaluates a new accept, giving back-to-back throughput of 1 per cycle at stall 0.
  - Without a new accept, next state is IDLE.
- In range: `data_addr_i[31:ADDR_WIDTH]` = 0. Word index = `data_addr_i[ADDR_WIDTH-1:2]`. `data_addr_i[1:0]` is ignored.
- Store: write only the bytes whose `data_be_i` bit is set. Response `data_rdata_o` = 0.
- Load: return the full word regardless of `data_be_i`.
- Out of range: stores are dropped. Loads return `OOR_RDATA`. The transaction is still granted and answered normally.
- `served_cnt_o` increments on every cycle with `data_gnt_o` = 1 and saturates at 16'hFFFF.
- Memory contents are not reset. The bench must write before it reads.

## Timing
- Reset values: state IDLE, `data_gnt_o` 0 (masked by `rst_ni`), `data_rvalid_o` 0, `data_rdata_o` 0, `busy_o` 0, `served_cnt_o` 0, stall counter 0, LFSR 16'hACE1.
- Grant latency from `data_req_i` rise is the stall value N: grant in cycle N.
- `data_rvalid_o` is asserted exactly 1 cycle after the grant cycle.
- At most one outstanding transaction.
- Store then load to the same word back-to-back: the load returns the new data (write at grant edge, read at next grant edge).
- `test_mode_i` high:
  - `data_gnt_o` is forced 0.
  - STALL aborts to IDLE.
  - A RESP already in progress still completes its rvalid cycle.
  - No memory writes occur.
- Reset mid-transaction: immediate return to reset values. A pending rvalid is lost.

## Configuration
- `DATA_RESP_RANDOM_STALL_EN`:
  - Defined: stall value = `lfsr[1:0]` (0..3). The LFSR is 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle after reset. `GNT_STALL` is ignored.
  - Undefined: stall value = `GNT_STALL`. No LFSR is instantiated.

## Test plan
- Stall 0: store 32'h1234_5678 to address 0x40 with be 4'hF, then load 0x40 → gnt in each request cycle, rvalid 1 cycle later, load rdata = 32'h1234_5678, `served_cnt_o` = 2.
- Byte enables: store 32'hAABB_CCDD to 0x40 with be 4'b0101 over the previous data → load returns 32'h12BB_56DD.
- `GNT_STALL` = 3: hold req → gnt in cycle 3, rvalid in cycle 4. Drop req in cycle 1 → no gnt, FSM in IDLE, `served_cnt_o` unchanged.
- Out of range (`ADDR_WIDTH` 16): load 0x0001_0000 → rvalid with 32'hDEAD_BEEF. Store to 0x0001_0000 → memory unchanged.
- `test_mode_i` = 1 with req held 10 cycles → gnt stays 0, no writes. Dropping `test_mode_i` → grant per stall rule.
- Saturation and reset: preset count to 16'hFFFE, issue 3 grants → 16'hFFFF. Assert `rst_ni` low mid-STALL → all outputs return to 0 asynchronously.
